// File: rtl/axi4_lite_subordinate.sv
// AXI4-Lite subordinate backed by a MEM_BYTES on-chip RAM with independent read/write FSMs.
// Optional: define AXI_SUB_UNALIGNED_SLVERR_EN to answer unaligned accesses with SLVERR.
module axi4_lite_subordinate #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4,
    parameter int MEM_BYTES = 4096
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ID_W-1:0]     ARID,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RVALID,
    input  logic                RREADY
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_BYTES);
    localparam int WORDS  = MEM_BYTES / STRB_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    function automatic logic [1:0] resp_for(input logic [ADDR_W-1:0] addr);
        logic [1:0] r;
        if ((addr >> IDX_W) != '0) begin
            r = RESP_DECERR;
`ifdef AXI_SUB_UNALIGNED_SLVERR_EN
        end else if (addr[OFF_W-1:0] != '0) begin
            r = RESP_SLVERR;
`endif
        end else begin
            r = RESP_OKAY;
        end
        return r;
    endfunction

    logic [DATA_W-1:0] mem_r [WORDS];

    w_state_t            w_state_r, w_state_s;
    logic                awready_r, awready_s, wready_r, wready_s;
    logic                aw_got_r, aw_got_s, w_got_r, w_got_s;
    logic [ADDR_W-1:0]   aw_addr_r, aw_addr_s;
    logic [ID_W-1:0]     aw_id_r, aw_id_s;
    logic [DATA_W-1:0]   wdata_r, wdata_s;
    logic [STRB_W-1:0]   wstrb_r, wstrb_s;
    logic                bvalid_r, bvalid_s;
    logic [ID_W-1:0]     bid_r, bid_s;
    logic [1:0]          bresp_r, bresp_s, wr_resp_s;
    logic                wr_en_s;

    r_state_t            r_state_r, r_state_s;
    logic                arready_r, arready_s, rvalid_r, rvalid_s, rd_load_s;
    logic [ID_W-1:0]     rid_r, rid_s;
    logic [1:0]          rresp_r, rresp_s, rd_resp_s;
    logic [DATA_W-1:0]   rdata_r;

    // Write channel next-state: gather AW and W in any order, commit when both are held
    always_comb begin
        w_state_s = w_state_r;
        awready_s = awready_r;
        wready_s  = wready_r;
        aw_got_s  = aw_got_r;
        w_got_s   = w_got_r;
        aw_addr_s = aw_addr_r;
        aw_id_s   = aw_id_r;
        wdata_s   = wdata_r;
        wstrb_s   = wstrb_r;
        bvalid_s  = bvalid_r;
        bid_s     = bid_r;
        bresp_s   = bresp_r;
        wr_en_s   = 1'b0;
        wr_resp_s = resp_for(aw_addr_r);
        case (w_state_r)
            W_IDLE: begin
                if (AWVALID && awready_r) begin
                    aw_got_s  = 1'b1;
                    aw_addr_s = AWADDR;
                    aw_id_s   = AWID;
                end else begin
                    aw_got_s  = aw_got_r;
                end
                if (WVALID && wready_r) begin
                    w_got_s = 1'b1;
                    wdata_s = WDATA;
                    wstrb_s = WSTRB;
                end else begin
                    w_got_s = w_got_r;
                end
                wr_resp_s = resp_for(aw_addr_s);
                if (aw_got_s && w_got_s) begin
                    wr_en_s   = (wr_resp_s == RESP_OKAY);
                    bvalid_s  = 1'b1;
                    bid_s     = aw_id_s;
                    bresp_s   = wr_resp_s;
                    awready_s = 1'b0;
                    wready_s  = 1'b0;
                    aw_got_s  = 1'b0;
                    w_got_s   = 1'b0;
                    w_state_s = W_RESP;
                end else begin
                    awready_s = !aw_got_s;
                    wready_s  = !w_got_s;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    bvalid_s  = 1'b0;
                    awready_s = 1'b1;
                    wready_s  = 1'b1;
                    w_state_s = W_IDLE;
                end else begin
                    bvalid_s  = 1'b1;
                end
            end
            default: begin
                w_state_s = W_IDLE;
                awready_s = 1'b0;
                wready_s  = 1'b0;
                bvalid_s  = 1'b0;
            end
        endcase
    end

    // Write channel state and response registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            aw_got_r  <= 1'b0;
            w_got_r   <= 1'b0;
            aw_addr_r <= '0;
            aw_id_r   <= '0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
            bvalid_r  <= 1'b0;
            bid_r     <= '0;
            bresp_r   <= 2'b00;
        end else begin
            w_state_r <= w_state_s;
            awready_r <= awready_s;
            wready_r  <= wready_s;
            aw_got_r  <= aw_got_s;
            w_got_r   <= w_got_s;
            aw_addr_r <= aw_addr_s;
            aw_id_r   <= aw_id_s;
            wdata_r   <= wdata_s;
            wstrb_r   <= wstrb_s;
            bvalid_r  <= bvalid_s;
            bid_r     <= bid_s;
            bresp_r   <= bresp_s;
        end
    end

    // RAM byte-lane write; contents deliberately have no reset
    always_ff @(posedge ACLK) begin
        if (wr_en_s) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wstrb_s[i]) begin
                    mem_r[aw_addr_s[IDX_W-1:OFF_W]][i*8 +: 8] <= wdata_s[i*8 +: 8];
                end
            end
        end
    end

    // Read channel next-state: accept AR in idle, hold R outputs until RREADY
    always_comb begin
        r_state_s = r_state_r;
        arready_s = arready_r;
        rvalid_s  = rvalid_r;
        rid_s     = rid_r;
        rresp_s   = rresp_r;
        rd_load_s = 1'b0;
        rd_resp_s = resp_for(ARADDR);
        case (r_state_r)
            R_IDLE: begin
                arready_s = 1'b1;
                if (ARVALID && arready_r) begin
                    rd_load_s = 1'b1;
                    rvalid_s  = 1'b1;
                    rid_s     = ARID;
                    rresp_s   = rd_resp_s;
                    arready_s = 1'b0;
                    r_state_s = R_DATA;
                end else begin
                    rvalid_s  = 1'b0;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    rvalid_s  = 1'b0;
                    arready_s = 1'b1;
                    r_state_s = R_IDLE;
                end else begin
                    rvalid_s  = 1'b1;
                end
            end
            default: begin
                r_state_s = R_IDLE;
                arready_s = 1'b0;
                rvalid_s  = 1'b0;
            end
        endcase
    end

    // Read channel registers; RAM sampled with pre-write contents on a same-edge collision
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rid_r     <= '0;
            rresp_r   <= 2'b00;
            rdata_r   <= '0;
        end else begin
            r_state_r <= r_state_s;
            arready_r <= arready_s;
            rvalid_r  <= rvalid_s;
            rid_r     <= rid_s;
            rresp_r   <= rresp_s;
            if (rd_load_s) begin
                rdata_r <= (rd_resp_s == RESP_OKAY) ? mem_r[ARADDR[IDX_W-1:OFF_W]] : '0;
            end
        end
    end

    assign AWREADY = awready_r;
    assign WREADY  = wready_r;
    assign BVALID  = bvalid_r;
    assign BID     = bid_r;
    assign BRESP   = bresp_r;
    assign ARREADY = arready_r;
    assign RVALID  = rvalid_r;
    assign RID     = rid_r;
    assign RRESP   = rresp_r;
    assign RDATA   = rdata_r;

endmodule

// File: tb/tb_axi4_lite_subordinate.sv
// Scoreboard bench for axi4_lite_subordinate: directed plan cases plus randomized traffic
// checked against an associative-array memory model.
module tb_axi4_lite_subordinate;
    localparam int ADDR_W = 32, DATA_W = 64, ID_W = 4, MEM_BYTES = 4096;

    logic ACLK = 1'b0, ARESETn = 1'b0;
    logic [ID_W-1:0] AWID = '0, ARID = '0, BID, RID;
    logic [ADDR_W-1:0] AWADDR = '0, ARADDR = '0;
    logic AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
    logic AWREADY, WREADY, BVALID, ARREADY, RVALID;
    logic [DATA_W-1:0] WDATA = '0, RDATA;
    logic [DATA_W/8-1:0] WSTRB = '0;
    logic [1:0] BRESP, RRESP;

    always #5 ACLK = ~ACLK;

    axi4_lite_subordinate #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MEM_BYTES(MEM_BYTES)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t bq[$];
    exp_t rq[$];
    exp_t mon_b, mon_r;
    logic [63:0] mdl [int];
    int written[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        if (a >= 32'(MEM_BYTES)) return 2'b11;
`ifdef AXI_SUB_UNALIGNED_SLVERR_EN
        if (a[2:0] != 3'd0) return 2'b10;
`endif
        return 2'b00;
    endfunction

    // Monitor: every completed B/R handshake is popped from the scoreboard and compared
    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (BVALID && BREADY) begin
                if (bq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL b_unexpected: got BID=%h BRESP=%h with nothing expected", BID, BRESP);
                end else begin
                    mon_b = bq.pop_front();
                    check("b_resp", {BID, BRESP}, {mon_b.id, mon_b.resp});
                end
            end
            if (RVALID && RREADY) begin
                if (rq.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL r_unexpected: got RID=%h RDATA=%h with nothing expected", RID, RDATA);
                end else begin
                    mon_r = rq.pop_front();
                    check("r_beat", {RID, RRESP, RDATA}, {mon_r.id, mon_r.resp, mon_r.data});
                end
            end
        end
    end

    task automatic send_aw(input logic [31:0] a, input logic [ID_W-1:0] id);
        AWADDR = a; AWID = id; AWVALID = 1'b1;
        for (int t = 0; t <= 50; t++) begin
            @(negedge ACLK);
            if (AWREADY) break;
            if (t == 50) begin n_cmp++; n_err++; $display("FAIL aw_timeout: got no AWREADY, required within 50 cycles"); end
        end
        @(posedge ACLK); #1 AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] d, input logic [7:0] s);
        WDATA = d; WSTRB = s; WVALID = 1'b1;
        for (int t = 0; t <= 50; t++) begin
            @(negedge ACLK);
            if (WREADY) break;
            if (t == 50) begin n_cmp++; n_err++; $display("FAIL w_timeout: got no WREADY, required within 50 cycles"); end
        end
        @(posedge ACLK); #1 WVALID = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            input logic [ID_W-1:0] id, input int lead, input int stall);
        exp_t e;
        int k;
        e.id = id; e.resp = exp_resp(a); e.data = '0;
        bq.push_back(e);
        if (e.resp == 2'b00) begin
            k = int'(a >> 3);
            if (!mdl.exists(k)) begin mdl[k] = 64'd0; written.push_back(k); end
            for (int i = 0; i < 8; i++) if (s[i]) mdl[k][i*8 +: 8] = d[i*8 +: 8];
        end
        fork
            begin
                if (lead > 0) begin repeat (lead) @(posedge ACLK); #1; end
                send_aw(a, id);
            end
            send_w(d, s);
        join
        check("b_latency", {31'd0, BVALID}, 32'd1);
        for (int c = 0; c < stall; c++) begin
            check("b_stall_hold", {BVALID, BID, BRESP}, {1'b1, e.id, e.resp});
            @(posedge ACLK); #1;
        end
        BREADY = 1'b1;
        for (int t = 0; t <= 50; t++) begin
            @(negedge ACLK);
            if (BVALID) break;
            if (t == 50) begin n_cmp++; n_err++; $display("FAIL b_timeout: got no BVALID, required within 50 cycles"); end
        end
        @(posedge ACLK); #1 BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [ID_W-1:0] id, input int stall);
        exp_t e;
        e.id = id; e.resp = exp_resp(a);
        e.data = (e.resp == 2'b00) ? mdl[int'(a >> 3)] : 64'd0;
        rq.push_back(e);
        ARADDR = a; ARID = id; ARVALID = 1'b1;
        for (int t = 0; t <= 50; t++) begin
            @(negedge ACLK);
            if (ARREADY) break;
            if (t == 50) begin n_cmp++; n_err++; $display("FAIL ar_timeout: got no ARREADY, required within 50 cycles"); end
        end
        @(posedge ACLK); #1 ARVALID = 1'b0;
        check("r_latency", {31'd0, RVALID}, 32'd1);
        for (int c = 0; c < stall; c++) begin
            check("r_stall_hold", {RVALID, RID, RRESP, RDATA}, {1'b1, e.id, e.resp, e.data});
            @(posedge ACLK); #1;
        end
        RREADY = 1'b1;
        for (int t = 0; t <= 50; t++) begin
            @(negedge ACLK);
            if (RVALID) break;
            if (t == 50) begin n_cmp++; n_err++; $display("FAIL r_timeout: got no RVALID, required within 50 cycles"); end
        end
        @(posedge ACLK); #1 RREADY = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [7:0] s;
        int k;
        #2;
        check("reset_state", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, BID, RID, RDATA},
              {5'b00000, 2'b00, 2'b00, 4'h0, 4'h0, 64'd0});
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;

        do_write(32'h0000, 64'h0123_4567_89AB_CDEF, 8'hFF, 4'h1, 0, 0);
        do_write(32'h0020, 64'h1111_2222_3333_4444, 8'hFF, 4'h2, 0, 0);
        do_read (32'h0020, 4'h3, 0);
        do_write(32'h0FF0, 64'h1234_5678_ABCD_EF00, 8'hFF, 4'h4, 0, 0);
        do_read (32'h0FF0, 4'h5, 0);
        do_write(32'h2000, 64'hCAFE_BABE_0011_2233, 8'hFF, 4'h6, 0, 0);
        do_read (32'h2000, 4'h7, 0);
        do_read (32'h0000, 4'h8, 0);
        do_write(32'h0050, 64'h1010_2020_3030_4040, 8'hFF, 4'h9, 0, 0);
        do_write(32'h0050, 64'h9999_AAAA_BBBB_CCCC, 8'hFF, 4'hA, 0, 0);
        do_read (32'h0050, 4'hB, 0);
        do_write(32'h0100, 64'hAAAA_0000_0000_000A, 8'hFF, 4'h1, 0, 0);
        do_write(32'h0200, 64'hBBBB_0000_0000_000B, 8'hFF, 4'h2, 0, 0);
        do_write(32'h0300, 64'hCCCC_0000_0000_000C, 8'hFF, 4'h3, 0, 0);
        do_read (32'h0100, 4'h4, 0);
        do_read (32'h0200, 4'h5, 0);
        do_read (32'h0300, 4'h6, 0);
        do_write(32'h0100, 64'hA1A1_A1A1_0000_0001, 8'hFF, 4'hC, 2, 3);
        do_write(32'h0200, 64'hB2B2_B2B2_0000_0002, 8'hFF, 4'hD, 2, 3);
        do_write(32'h0300, 64'hC3C3_C3C3_0000_0003, 8'hFF, 4'hE, 2, 3);
        do_read (32'h0100, 4'h7, 3);
        do_read (32'h0200, 4'h8, 3);
        do_read (32'h0300, 4'h9, 3);
        do_write(32'h0040, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 4'h0, 0, 0);
        do_write(32'h0040, 64'h0, 8'h0F, 4'h1, 0, 0);
        do_read (32'h0040, 4'h2, 0);
        check("partial_strb_model", mdl[8], 64'hFFFF_FFFF_0000_0000);

        // Read and write to the same word on the same edge: read sees old contents
        fork
            do_read(32'h0050, 4'h3, 0);
            begin
                wait (rq.size() != 0);
                do_write(32'h0050, 64'h5555_6666_7777_8888, 8'hFF, 4'h4, 0, 0);
            end
        join
        do_read(32'h0050, 4'h5, 0);

        // Reset while a write is half captured: nothing commits
        do_write(32'h0060, 64'h6060_6060_6060_6060, 8'hFF, 4'h6, 0, 0);
        AWADDR = 32'h0060; AWID = 4'h7; AWVALID = 1'b1;
        @(negedge ACLK);
        @(posedge ACLK); #1 AWVALID = 1'b0;
        WDATA = 64'hDEAD_DEAD_DEAD_DEAD; WSTRB = 8'hFF; WVALID = 1'b1;
        #2 ARESETn = 1'b0;
        #1 check("reset_mid_write", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b00000);
        WVALID = 1'b0;
        repeat (2) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        repeat (2) @(posedge ACLK);
        #1;
        do_read(32'h0060, 4'h8, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                if ($urandom_range(0, 4) == 0) a = 32'h1000 + ($urandom_range(0, 32'h00FF_FFFF) << 3) + 32'($urandom_range(0, 7));
                else a = ($urandom_range(0, 511) << 3) + 32'($urandom_range(0, 7));
                k = int'(a >> 3);
                s = (a < 32'(MEM_BYTES) && mdl.exists(k)) ? 8'($urandom) : 8'hFF;
                do_write(a, {$urandom, $urandom}, s, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
            end else begin
                if ($urandom_range(0, 4) == 0) a = 32'h1000 + ($urandom_range(0, 32'h00FF_FFFF) << 3);
                else a = (32'(written[$urandom_range(0, written.size() - 1)]) << 3) + 32'($urandom_range(0, 7));
                do_read(a, 4'($urandom), $urandom_range(0, 2));
            end
        end

        repeat (5) @(posedge ACLK);
        #1;
        check("b_queue_drained", 32'(bq.size()), 32'd0);
        check("r_queue_drained", 32'(rq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
